// File: rtl/sr_pq_param.sv
// Parametrised systolic shift-register priority queue with stable ordering among
// equal keys, single-cycle replace, occupancy count and overflow/underflow pulses.
module sr_pq_param #(
    parameter int unsigned KW        = 4,
    parameter int unsigned VW        = 4,
    parameter int unsigned DEPTH     = 16,
    parameter bit          MIN_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enq,
    input  logic                         deq,
    input  logic [KW-1:0]                kvi_key,
    input  logic [VW-1:0]                kvi_val,
    output logic [KW-1:0]                kvo_key,
    output logic [VW-1:0]                kvo_val,
    output logic                         kvo_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         err_ovf,
    output logic                         err_udf
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          vld;
        logic [KW-1:0] key;
        logic [VW-1:0] val;
    } cell_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_INS,
        OP_DEL,
        OP_REP
    } op_e;

    cell_t           cell_q [DEPTH];
    cell_t           cell_d [DEPTH];
    cell_t           pad    [DEPTH+2];
    cell_t           new_cell;
    logic [DEPTH+1:0] ge_ext;
    logic [CW-1:0]   count_q, count_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_udf_q, err_udf_d;
    op_e             op;

    // Valid cells are contiguous from cell 0, so full/empty come from the end cells.
    assign full  = cell_q[DEPTH-1].vld;
    assign empty = ~cell_q[0].vld;

    always_comb begin
        op = OP_HOLD;
        unique case ({enq, deq})
            2'b10:   op = full  ? OP_HOLD : OP_INS;
            2'b01:   op = empty ? OP_HOLD : OP_DEL;
            2'b11:   op = empty ? OP_INS  : OP_REP;
            default: op = OP_HOLD;
        endcase
    end

    // Padded neighbour views: slot 0 and slot DEPTH+1 are empty cells, and
    // ge_ext[0]=1 lets cell 0 accept the new entry during a plain insert.
    always_comb begin
        pad[0]           = '0;
        pad[DEPTH+1]     = '0;
        ge_ext           = '0;
        ge_ext[0]        = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pad[i+1]    = cell_q[i];
            ge_ext[i+1] = cell_q[i].vld &&
                          (MIN_FIRST ? (cell_q[i].key <= kvi_key)
                                     : (cell_q[i].key >= kvi_key));
        end
    end

    // Each cell looks only at its own compare and its two neighbours.
    always_comb begin
        new_cell = '{vld: 1'b1, key: kvi_key, val: kvi_val};
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cell_d[i] = cell_q[i];
            unique case (op)
                OP_INS: begin
                    if (!ge_ext[i+1]) begin
                        cell_d[i] = ge_ext[i] ? new_cell : pad[i];
                    end
                end
                OP_DEL: cell_d[i] = pad[i+2];
                OP_REP: begin
                    if (ge_ext[i+2]) begin
                        cell_d[i] = pad[i+2];
                    end else if (i == 0 || ge_ext[i+1]) begin
                        cell_d[i] = new_cell;
                    end
                end
                default: cell_d[i] = cell_q[i];
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        unique case (op)
            OP_INS:  count_d = count_q + CW'(1);
            OP_DEL:  count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        err_ovf_d = enq && !deq && full;
        err_udf_d = deq && empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cell_q[i] <= '0;
            end
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cell_q[i] <= cell_d[i];
            end
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    // Invalid cells always hold zeros, so the head reads 0 when empty.
    assign kvo_key   = cell_q[0].key;
    assign kvo_val   = cell_q[0].val;
    assign kvo_valid = cell_q[0].vld;
    assign count     = count_q;
    assign err_ovf   = err_ovf_q;
    assign err_udf   = err_udf_q;

endmodule

// File: tb/tb_sr_pq_param.sv
// Directed bench for sr_pq_param: three instances (min-first DEPTH=16,
// min-first DEPTH=4, max-first DEPTH=4) share one stimulus bus.
module tb_sr_pq_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enq = 1'b0;
    logic       deq = 1'b0;
    logic [3:0] kvi_key = '0;
    logic [3:0] kvi_val = '0;

    logic [3:0] a_key, a_val, b_key, b_val, c_key, c_val;
    logic       a_vld, b_vld, c_vld;
    logic [4:0] a_count;
    logic [2:0] b_count, c_count;
    logic       a_full, a_empty, a_ovf, a_udf;
    logic       b_full, b_empty, b_ovf, b_udf;
    logic       c_full, c_empty, c_ovf, c_udf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_pq_param #(.KW(4), .VW(4), .DEPTH(16), .MIN_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi_key(kvi_key), .kvi_val(kvi_val),
        .kvo_key(a_key), .kvo_val(a_val), .kvo_valid(a_vld), .count(a_count),
        .full(a_full), .empty(a_empty), .err_ovf(a_ovf), .err_udf(a_udf));

    sr_pq_param #(.KW(4), .VW(4), .DEPTH(4), .MIN_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi_key(kvi_key), .kvi_val(kvi_val),
        .kvo_key(b_key), .kvo_val(b_val), .kvo_valid(b_vld), .count(b_count),
        .full(b_full), .empty(b_empty), .err_ovf(b_ovf), .err_udf(b_udf));

    sr_pq_param #(.KW(4), .VW(4), .DEPTH(4), .MIN_FIRST(1'b0)) dut_c (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi_key(kvi_key), .kvi_val(kvi_val),
        .kvo_key(c_key), .kvo_val(c_val), .kvo_valid(c_vld), .count(c_count),
        .full(c_full), .empty(c_empty), .err_ovf(c_ovf), .err_udf(c_udf));

    task automatic op(input logic e, input logic d, input logic [3:0] k, input logic [3:0] v);
        enq = e; deq = d; kvi_key = k; kvi_val = v;
        @(posedge clk); #1;
        enq = 1'b0; deq = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) op(1'b0, 1'b0, 4'h0, 4'h0);
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", a_empty); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", a_full); end
        checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", a_count); end
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", a_vld); end
        checks++; if ({a_key, a_val} !== 8'h00) begin errors++; $display("FAIL rst_head got %h want 00", {a_key, a_val}); end
        checks++; if ({a_ovf, a_udf} !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", {a_ovf, a_udf}); end
        checks++; if ({b_count, c_count} !== 6'd0) begin errors++; $display("FAIL rst_count_bc got %b want 0", {b_count, c_count}); end
    endtask

    task automatic test_min_order();
        do_reset();
        op(1'b1, 1'b0, 4'd5, 4'hA);
        op(1'b1, 1'b0, 4'd2, 4'hB);
        op(1'b1, 1'b0, 4'd9, 4'hC);
        op(1'b1, 1'b0, 4'd2, 4'hD);
        checks++; if (a_count !== 5'd4) begin errors++; $display("FAIL min_count got %0d want 4", a_count); end
        checks++; if ({a_key, a_val} !== 8'h2B) begin errors++; $display("FAIL min_head0 got %h want 2B", {a_key, a_val}); end
        op(1'b0, 1'b1, 4'd0, 4'h0);
        checks++; if ({a_key, a_val} !== 8'h2D) begin errors++; $display("FAIL min_head1 got %h want 2D", {a_key, a_val}); end
        op(1'b0, 1'b1, 4'd0, 4'h0);
        checks++; if ({a_key, a_val} !== 8'h5A) begin errors++; $display("FAIL min_head2 got %h want 5A", {a_key, a_val}); end
        op(1'b0, 1'b1, 4'd0, 4'h0);
        checks++; if ({a_key, a_val} !== 8'h9C) begin errors++; $display("FAIL min_head3 got %h want 9C", {a_key, a_val}); end
        checks++; if (a_count !== 5'd1) begin errors++; $display("FAIL min_count1 got %0d want 1", a_count); end
        op(1'b0, 1'b1, 4'd0, 4'h0);
        checks++; if ({a_empty, a_vld, a_key} !== 6'b10_0000) begin errors++; $display("FAIL min_drained got %b want 100000", {a_empty, a_vld, a_key}); end
        checks++; if (a_udf !== 1'b0) begin errors++; $display("FAIL min_no_udf got %b want 0", a_udf); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 4; k++) op(1'b1, 1'b0, 4'(k), 4'(k + 8));
        checks++; if ({b_full, b_count} !== 4'b1_100) begin errors++; $display("FAIL ovf_full got %b want 1100", {b_full, b_count}); end
        checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", b_ovf); end
        op(1'b1, 1'b0, 4'd0, 4'hF);
        checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", b_ovf); end
        checks++; if (b_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", b_count); end
        checks++; if ({b_key, b_val} !== 8'h19) begin errors++; $display("FAIL ovf_head got %h want 19", {b_key, b_val}); end
        op(1'b0, 1'b0, 4'd0, 4'h0);
        checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", b_ovf); end
    endtask

    task automatic test_underflow();
        do_reset();
        op(1'b0, 1'b1, 4'd0, 4'h0);
        checks++; if (a_udf !== 1'b1) begin errors++; $display("FAIL udf_pulse got %b want 1", a_udf); end
        checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL udf_count got %0d want 0", a_count); end
        op(1'b0, 1'b0, 4'd0, 4'h0);
        checks++; if (a_udf !== 1'b0) begin errors++; $display("FAIL udf_clear got %b want 0", a_udf); end
        op(1'b1, 1'b1, 4'd6, 4'hE);
        checks++; if (a_udf !== 1'b1) begin errors++; $display("FAIL udf_rep_pulse got %b want 1", a_udf); end
        checks++; if (a_count !== 5'd1) begin errors++; $display("FAIL udf_rep_count got %0d want 1", a_count); end
        checks++; if ({a_vld, a_key, a_val} !== 9'h16E) begin errors++; $display("FAIL udf_rep_head got %h want 16E", {a_vld, a_key, a_val}); end
    endtask

    task automatic test_replace();
        do_reset();
        op(1'b1, 1'b0, 4'd3, 4'h1);
        op(1'b1, 1'b0, 4'd7, 4'h2);
        op(1'b1, 1'b1, 4'd5, 4'h3);
        checks++; if (a_count !== 5'd2) begin errors++; $display("FAIL rep_count got %0d want 2", a_count); end
        checks++; if ({a_key, a_val} !== 8'h53) begin errors++; $display("FAIL rep_head got %h want 53", {a_key, a_val}); end
        op(1'b0, 1'b1, 4'd0, 4'h0);
        checks++; if ({a_key, a_val} !== 8'h72) begin errors++; $display("FAIL rep_after got %h want 72", {a_key, a_val}); end
        do_reset();
        for (int k = 1; k <= 4; k++) op(1'b1, 1'b0, 4'(k), 4'(k + 8));
        op(1'b1, 1'b1, 4'd5, 4'h0);
        checks++; if ({b_full, b_count} !== 4'b1_100) begin errors++; $display("FAIL rep_full_count got %b want 1100", {b_full, b_count}); end
        checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL rep_full_ovf got %b want 0", b_ovf); end
        checks++; if ({b_key, b_val} !== 8'h2A) begin errors++; $display("FAIL rep_full_head got %h want 2A", {b_key, b_val}); end
        op(1'b0, 1'b1, 4'd0, 4'h0);
        checks++; if ({b_key, b_val} !== 8'h3B) begin errors++; $display("FAIL rep_drain1 got %h want 3B", {b_key, b_val}); end
        op(1'b0, 1'b1, 4'd0, 4'h0);
        checks++; if ({b_key, b_val} !== 8'h4C) begin errors++; $display("FAIL rep_drain2 got %h want 4C", {b_key, b_val}); end
        op(1'b0, 1'b1, 4'd0, 4'h0);
        checks++; if ({b_key, b_val, b_count} !== 11'b0101_0000_001) begin errors++; $display("FAIL rep_drain3 got %b want 01010000001", {b_key, b_val, b_count}); end
    endtask

    task automatic test_max_and_rst();
        do_reset();
        op(1'b1, 1'b0, 4'd3, 4'hA);
        op(1'b1, 1'b0, 4'd8, 4'hB);
        op(1'b1, 1'b0, 4'd1, 4'hC);
        checks++; if ({c_key, c_val} !== 8'h8B) begin errors++; $display("FAIL max_head got %h want 8B", {c_key, c_val}); end
        checks++; if (c_count !== 3'd3) begin errors++; $display("FAIL max_count got %0d want 3", c_count); end
        rst = 1'b1;
        op(1'b1, 1'b0, 4'd9, 4'hD);
        rst = 1'b0;
        checks++; if ({c_count, c_vld, c_empty} !== 5'b000_0_1) begin errors++; $display("FAIL max_rst got %b want 00001", {c_count, c_vld, c_empty}); end
        op(1'b0, 1'b0, 4'd0, 4'h0);
        checks++; if ({c_count, c_vld, c_key} !== 8'h00) begin errors++; $display("FAIL max_rst_hold got %h want 00", {c_count, c_vld, c_key}); end
    endtask

    initial begin
        test_reset();
        test_min_order();
        test_overflow();
        test_underflow();
        test_replace();
        test_max_and_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_pq_param.md
Name: sr_pq_param

Overview:
Parametrised shift-register priority queue, the next generation of sr_pq. It is generalised in key/value width, depth and ordering mode (min-first or max-first). It adds single-cycle replace (simultaneous enq+deq), stable FIFO ordering among equal keys, an occupancy count and overflow/underflow flags. It sits under the same pq_if-style simulation top as a drop-in device, and is synthesizable for the HWPQ area/speed study.

Parameters:
KW, 4, key width in bits
VW, 4, value (payload) width in bits
DEPTH, 16, number of storage cells (>=2)
MIN_FIRST, 1, 1 = smallest key is highest priority; 0 = largest key is highest priority

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
enq  input  1  enqueue request, sampled at rising edge
deq  input  1  dequeue request, sampled at rising edge
kvi_key  input  KW  key to enqueue
kvi_val  input  VW  value to enqueue
kvo_key  output  KW  key of head (highest-priority) entry
kvo_val  output  VW  value of head entry
kvo_valid  output  1  head entry valid (== !empty)
count  output  $clog2(DEPTH+1)  number of stored entries
full  output  1  count == DEPTH
empty  output  1  count == 0
err_ovf  output  1  one-cycle pulse: enq rejected because full
err_udf  output  1  one-cycle pulse: deq requested while empty

Behaviour:
- Storage: cells 0..DEPTH-1, each {valid, key, val}. Valid cells are contiguous from cell 0; cell 0 is the head.
- Priority: "a beats b" means a<b when MIN_FIRST=1 and a>b when MIN_FIRST=0. Comparisons are unsigned, KW bits.
- Ordering is stable: a new entry is placed behind every existing entry with an equal key.
- All outputs are registered or derived from registered state. Results of an operation at edge N are visible after edge N; there is no combinational path from inputs to outputs.
- Reset (rst=1 at an edge):
  - all cells are invalidated; count=0, empty=1, full=0, kvo_valid=0, kvo_key=0, kvo_val=0, err_ovf=0, err_udf=0.
  - rst dominates any enq/deq in the same cycle.
- Idle (enq=0, deq=0): state is held; err flags are 0.
- Enq only, not full:
  - p = number of valid cells whose key beats or equals kvi_key.
  - cells p..count-1 shift to p+1..count; cell p gets the new entry; count+1.
- Enq only, full: state is unchanged, err_ovf=1 for one cycle. No eviction.
- Deq only, not empty: cells 1..count-1 shift to 0..count-2; the last valid cell is invalidated; count-1.
- Deq only, empty: state is unchanged, err_udf=1 for one cycle.
- Enq+deq, not empty (replace):
  - the head is removed and the new entry is inserted in the same cycle; count is unchanged (legal when full).
  - p = number of cells in 1..count-1 whose key beats or equals kvi_key.
  - cells 1..p shift to 0..p-1; cell p gets the new entry.
- Enq+deq, empty: behaves as enq only; err_udf=1 for one cycle; count becomes 1.
- Each cell update depends only on its own compare, its neighbours and the op decode, so the critical path is independent of DEPTH (systolic). A DEPTH-wide priority encoder is not permitted.
- After any operation, kvo_* = cell 0 contents and kvo_valid = cell 0 valid. kvo_key/kvo_val are 0 when empty.
- Back-to-back operations every cycle are supported with no stall, bubble or busy output.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, kvo_valid=0, kvo_key=0, err_ovf=err_udf=0.
- MIN_FIRST=1: enq (5,a),(2,b),(9,c),(2,d) on consecutive cycles -> count=4, head (2,b). Four deqs -> heads (2,d),(5,a),(9,c), then empty=1.
- DEPTH=4: enq keys 1,2,3,4 -> full=1. Then enq key 0 with no deq -> err_ovf pulses once, count stays 4, head still 1.
- Empty queue, deq alone -> err_udf pulses once, count 0. Then enq+deq of (6,e) in one cycle -> err_udf=1, count=1, head (6,e).
- Queue {3,7}: enq 5 + deq in the same cycle -> count=2, head 5; deq -> head 7. Repeat the replace at full DEPTH=4 -> count stays 4, no err_ovf.
- MIN_FIRST=0: enq 3,8,1 -> head 8. Assert rst during a further enq -> after that edge count=0, kvo_valid=0, and the enq is lost.
